// File: rtl/uart_word_tx_if.sv
// Word handshake bundle for uart_word_tx: word data, valid, and the block's ready.
interface uart_word_tx_if #(
    parameter int unsigned bytes_p = 4
) ();
    logic [8*bytes_p-1:0] data_i;
    logic                 v_i;
    logic                 ready_o;

    modport master (output data_i, output v_i, input ready_o);
    modport slave  (input data_i, input v_i, output ready_o);
endinterface

// File: rtl/uart_word_tx.sv
// Multi-byte 8N1 UART transmitter: LSB byte first, LSB bit first, internal baud timer.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
module uart_word_tx #(
    parameter int unsigned clk_per_bit_p = 10416,
    parameter int unsigned bytes_p       = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    uart_word_tx_if.slave  in_if,
    output logic           tx_o,
    output logic           busy_o,
    output logic           done_o
);
    localparam int unsigned TW = $clog2(clk_per_bit_p);
    localparam int unsigned BW = (bytes_p > 1) ? $clog2(bytes_p) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(clk_per_bit_p - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(bytes_p - 1);

`ifdef UART_WORD_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [TW-1:0]        timer;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        byte_idx;
    logic [8*bytes_p-1:0] word;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            word          <= '0;
            tx_o          <= 1'b1;
            in_if.ready_o <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (in_if.v_i) begin
                        word          <= in_if.data_i;
                        state         <= START;
                        timer         <= '0;
                        byte_idx      <= '0;
                        tx_o          <= 1'b0;
                        in_if.ready_o <= 1'b0;
                        busy_o        <= 1'b1;
                    end
                end
                START: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx_o    <= word[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= ^word[7:0];
`else
                            state <= STOP;
                            tx_o  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= word[3'(bit_idx + 3'd1)];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_WORD_TX_PARITY_EN
                PARITY: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            // done_o rides on the single IDLE cycle that precedes any next handshake
                            state         <= IDLE;
                            done_o        <= 1'b1;
                            in_if.ready_o <= 1'b1;
                            busy_o        <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            word     <= word >> 8;
                            state    <= START;
                            tx_o     <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    tx_o          <= 1'b1;
                    in_if.ready_o <= 1'b1;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end
endmodule
